memarb: RTL and testbench
=========================

Name: memarb

Overview:
- Shares one external byte-wide memory port (SDRAM controller front end) among the four mapper-side memory requesters: PRG ROM, CHR ROM, PRG RAM and CHR RAM.
- Sits between the mapper block and the memory controller.
- Maps each requester's local address into one 23-bit physical space.
- Arbitrates round-robin, sequences one transaction at a time, and guards against a hung memory with a timeout.

Parameters:
- TIMEOUT, 255: cycles to wait for memack before aborting a transaction (8-bit counter, must be 1..255).
- PRGRAM_BASE, 23'h400000: physical base of PRG RAM.
- CHRRAM_BASE, 23'h408000: physical base of CHR RAM.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- promaddr  in  21  PRG ROM byte address
- promreq  in  1  PRG ROM read request (level)
- promack  out  1  PRG ROM completion pulse
- cromaddr  in  21  CHR ROM byte address
- cromreq  in  1  CHR ROM read request
- cromack  out  1  CHR ROM completion pulse
- prgramaddr  in  15  PRG RAM address
- prgramwdata  in  8  PRG RAM write data
- prgramwr  in  1  1 = write, 0 = read
- prgramreq  in  1  PRG RAM request
- prgramack  out  1  PRG RAM completion pulse
- chrramaddr  in  13  CHR RAM address
- chrramwdata  in  8  CHR RAM write data
- chrramwr  in  1  1 = write
- chrramreq  in  1  CHR RAM request
- chrramack  out  1  CHR RAM completion pulse
- rdata  out  8  read data, shared by all clients, valid in the ack cycle
- memaddr  out  23  physical address
- memwdata  out  8  write data
- memwr  out  1  write strobe qualifier
- memreq  out  1  memory request
- memack  in  1  memory completion; memrdata valid in the same cycle
- memrdata  in  8  memory read data
- timeout  out  1  sticky: a transaction was aborted

Behaviour:
- Reset (async, resetn=0) drives the following values:
  - all acks 0, memreq 0, memwr 0, memaddr 0, memwdata 0, rdata 0, timeout 0;
  - state IDLE, round-robin pointer to client 0, cooldown mask clear.
- Client index order: 0 = crom, 1 = chrram, 2 = prom, 3 = prgram.
- Physical address map:
  - prom → {2'b00, promaddr}
  - crom → {2'b01, cromaddr}
  - prgram → PRGRAM_BASE + prgramaddr
  - chrram → CHRRAM_BASE + chrramaddr
  - All arithmetic is 23-bit with no overflow check.
  - ROM clients always read (memwr 0).
- Request/ack rules:
  - A request is a level held until its ack.
  - Ack is exactly one cycle.
  - A client's req is masked for the cycle after its ack (cooldown), so a req still high then is not double-served.
  - A req dropped after latch is illegal but tolerated: the transaction completes and ack still pulses.
- FSM:
  - IDLE: eligible = req & ~cooldown. If any are eligible, round-robin picks the first eligible client at or after the pointer. Latch the client id, address, wdata and wr into the memory output registers. Go to ISSUE. The pointer becomes granted+1 mod 4.
  - ISSUE: memreq=1 with stable address/data; count cycles.
    - memack=1: latch memrdata into rdata (writes also update rdata; value unspecified), drop memreq, go to DONE.
    - Count reaches TIMEOUT with no memack: drop memreq, rdata=8'hFF, set timeout, go to DONE.
    - memack arriving in the same cycle as the TIMEOUT count is treated as success.
  - DONE: pulse the granted client's ack, set its cooldown bit, go to IDLE.
- Timing:
  - Latency, req to ack, is 3 cycles when memack returns in the first ISSUE cycle.
  - Throughput is at best one transaction per 3 cycles.
- Cooldown bits clear on the cycle after they are set.
- Simultaneous requests: one grant per arbitration, rotating. No client waits more than 3 transactions.
- memaddr/memwdata/memwr hold their last values outside ISSUE.
- Reset mid-transaction: memreq drops immediately and no ack is issued. The memory controller must tolerate an abandoned request.

Decomposition:
- Shared package holds:
  - client index constants (CL_CROM..CL_PRGRAM);
  - FSM state encodings (IDLE/ISSUE/DONE);
  - address region constants for the ROM regions.
- One sub-module: rr_arb4.
  - Inputs: 4-bit eligible, 2-bit pointer.
  - Outputs: valid and a 2-bit grant.
  - Purely combinational rotate-priority encoder.
  - The pointer register lives in memarb.

Test Plan:
- promreq with promaddr=21'h012345, memack on the first ISSUE cycle, memrdata=8'hA5 → memaddr=23'h012345, memwr=0, promack exactly 3 cycles after req, rdata=8'hA5.
- chrramwr=1, chrramaddr=13'h1FFF, wdata=8'h3C → memaddr=23'h409FFF, memwr=1, memwdata=8'h3C; chrramack pulses once.
- All four reqs held continuously with immediate memack → grant order crom, chrram, prom, prgram, crom…; each ack lasts one cycle and no client is served twice back-to-back while another is waiting.
- Req held high one extra cycle after ack (sole requester) → no second memory transaction starts from that stale cycle.
- memack never asserted → memreq high for TIMEOUT (255) cycles, then ack with rdata=8'hFF, timeout=1 and sticky until reset.
- resetn low while in ISSUE → memreq 0 asynchronously and no ack. After release, a fresh request is served normally starting from the client 0 pointer.

Source files
------------

// File: rtl/memarb_pkg.sv
// Shared constants for the mapper memory arbiter: client indices, FSM states
// and the physical region tags of the two ROMs.
package memarb_pkg;

  localparam logic [1:0] CL_CROM   = 2'd0;
  localparam logic [1:0] CL_CHRRAM = 2'd1;
  localparam logic [1:0] CL_PROM   = 2'd2;
  localparam logic [1:0] CL_PRGRAM = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [1:0] PROM_REGION = 2'b00;
  localparam logic [1:0] CROM_REGION = 2'b01;

endpackage

// File: rtl/memarb_rr_arb4.sv
// Four-way rotate-priority encoder: grants the first eligible client at or
// after the pointer, wrapping modulo 4.
module rr_arb4 (
  input  logic [3:0] eligible,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] grant
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    valid = |eligible;
    grant = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + i[1:0];
      if (!found && eligible[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memarb.sv
// Shares one byte-wide memory port among PRG ROM, CHR ROM, PRG RAM and CHR RAM:
// round-robin arbitration, one transaction at a time, with a hung-memory timeout.
module memarb
  import memarb_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [22:0] PRGRAM_BASE = 23'h400000,
  parameter logic [22:0] CHRRAM_BASE = 23'h408000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [20:0] promaddr,
  input  logic        promreq,
  output logic        promack,
  input  logic [20:0] cromaddr,
  input  logic        cromreq,
  output logic        cromack,
  input  logic [14:0] prgramaddr,
  input  logic [7:0]  prgramwdata,
  input  logic        prgramwr,
  input  logic        prgramreq,
  output logic        prgramack,
  input  logic [12:0] chrramaddr,
  input  logic [7:0]  chrramwdata,
  input  logic        chrramwr,
  input  logic        chrramreq,
  output logic        chrramack,
  output logic [7:0]  rdata,
  output logic [22:0] memaddr,
  output logic [7:0]  memwdata,
  output logic        memwr,
  output logic        memreq,
  input  logic        memack,
  input  logic [7:0]  memrdata,
  output logic        timeout
);

  // Last ISSUE cycle index: the counter starts at 0, so memreq stays up TIMEOUT cycles.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  cool_q, cool_d;
  logic [1:0]  cid_q, cid_d;
  logic [22:0] memaddr_q, memaddr_d;
  logic [7:0]  memwdata_q, memwdata_d;
  logic        memwr_q, memwr_d;
  logic        memreq_q, memreq_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  ack_q, ack_d;

  logic [3:0]  req_vec;
  logic [3:0]  eligible;
  logic        arb_valid;
  logic [1:0]  grant;
  logic [22:0] cand_addr;
  logic [7:0]  cand_wdata;
  logic        cand_wr;

  assign req_vec  = {prgramreq, promreq, chrramreq, cromreq};
  assign eligible = req_vec & ~cool_q;

  rr_arb4 u_arb (
    .eligible (eligible),
    .ptr      (ptr_q),
    .valid    (arb_valid),
    .grant    (grant)
  );

  always_comb begin
    cand_addr  = '0;
    cand_wdata = '0;
    cand_wr    = 1'b0;
    case (grant)
      CL_CROM:   cand_addr = {CROM_REGION, cromaddr};
      CL_CHRRAM: begin
        cand_addr  = CHRRAM_BASE + {10'd0, chrramaddr};
        cand_wdata = chrramwdata;
        cand_wr    = chrramwr;
      end
      CL_PROM:   cand_addr = {PROM_REGION, promaddr};
      default: begin
        cand_addr  = PRGRAM_BASE + {8'd0, prgramaddr};
        cand_wdata = prgramwdata;
        cand_wr    = prgramwr;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cool_d     = '0;
    cid_d      = cid_q;
    memaddr_d  = memaddr_q;
    memwdata_d = memwdata_q;
    memwr_d    = memwr_q;
    memreq_d   = memreq_q;
    rdata_d    = rdata_q;
    timeout_d  = timeout_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          cid_d      = grant;
          memaddr_d  = cand_addr;
          memwdata_d = cand_wdata;
          memwr_d    = cand_wr;
          memreq_d   = 1'b1;
          cnt_d      = '0;
          ptr_d      = grant + 2'd1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // memack wins over a timeout landing in the same cycle.
        if (memack) begin
          rdata_d  = memrdata;
          memreq_d = 1'b0;
          state_d  = ST_DONE;
        end else if (cnt_q == TMO_LAST) begin
          rdata_d   = 8'hFF;
          timeout_d = 1'b1;
          memreq_d  = 1'b0;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        // Cooldown masks the still-high req during the ack cycle.
        ack_d[cid_q]  = 1'b1;
        cool_d[cid_q] = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      ptr_q      <= CL_CROM;
      cool_q     <= '0;
      cid_q      <= '0;
      memaddr_q  <= '0;
      memwdata_q <= '0;
      memwr_q    <= 1'b0;
      memreq_q   <= 1'b0;
      rdata_q    <= '0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cool_q     <= cool_d;
      cid_q      <= cid_d;
      memaddr_q  <= memaddr_d;
      memwdata_q <= memwdata_d;
      memwr_q    <= memwr_d;
      memreq_q   <= memreq_d;
      rdata_q    <= rdata_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
    end
  end

  assign cromack   = ack_q[CL_CROM];
  assign chrramack = ack_q[CL_CHRRAM];
  assign promack   = ack_q[CL_PROM];
  assign prgramack = ack_q[CL_PRGRAM];
  assign rdata     = rdata_q;
  assign memaddr   = memaddr_q;
  assign memwdata  = memwdata_q;
  assign memwr     = memwr_q;
  assign memreq    = memreq_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_memarb.sv
// Scoreboard bench for memarb: stimulus pushes expected memory transactions and
// acks into queues; a negedge monitor pops and compares as the DUT presents them.
module tb_memarb;
  import memarb_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [20:0] promaddr = '0;
  logic        promreq = 1'b0;
  logic        promack;
  logic [20:0] cromaddr = '0;
  logic        cromreq = 1'b0;
  logic        cromack;
  logic [14:0] prgramaddr = '0;
  logic [7:0]  prgramwdata = '0;
  logic        prgramwr = 1'b0;
  logic        prgramreq = 1'b0;
  logic        prgramack;
  logic [12:0] chrramaddr = '0;
  logic [7:0]  chrramwdata = '0;
  logic        chrramwr = 1'b0;
  logic        chrramreq = 1'b0;
  logic        chrramack;
  logic [7:0]  rdata;
  logic [22:0] memaddr;
  logic [7:0]  memwdata;
  logic        memwr;
  logic        memreq;
  logic        memack = 1'b0;
  logic [7:0]  memrdata = '0;
  logic        timeout;

  always #5 clk = ~clk;

  memarb dut (
    .clk(clk), .resetn(resetn),
    .promaddr(promaddr), .promreq(promreq), .promack(promack),
    .cromaddr(cromaddr), .cromreq(cromreq), .cromack(cromack),
    .prgramaddr(prgramaddr), .prgramwdata(prgramwdata), .prgramwr(prgramwr),
    .prgramreq(prgramreq), .prgramack(prgramack),
    .chrramaddr(chrramaddr), .chrramwdata(chrramwdata), .chrramwr(chrramwr),
    .chrramreq(chrramreq), .chrramack(chrramack),
    .rdata(rdata), .memaddr(memaddr), .memwdata(memwdata), .memwr(memwr),
    .memreq(memreq), .memack(memack), .memrdata(memrdata), .timeout(timeout)
  );

  typedef struct {
    logic [1:0] cl;
    logic [7:0] rd;
    logic       chk_rd;
  } ack_t;

  typedef struct {
    logic [22:0] addr;
    logic        wr;
    logic [7:0]  wd;
  } mem_t;

  ack_t ack_exp[$];
  mem_t mem_exp[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int mem_mode = 1;
  logic [7:0] mem_data = 8'h00;
  int req_len = 0;
  int last_len = 0;
  int ack_total = 0;
  int mem_total = 0;
  logic memreq_prev = 1'b0;
  logic [3:0] acks_prev = 4'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: acks in the first ISSUE cycle when enabled, never otherwise.
  always @(negedge clk) begin
    memack   = memreq && (mem_mode == 1);
    memrdata = mem_data;
  end

  always @(negedge clk) begin : monitor
    logic [3:0] acks;
    ack_t ae;
    mem_t me;
    acks = {prgramack, promack, chrramack, cromack};
    if (acks != 4'b0) begin
      ack_total++;
      chk("ack_single_cycle", {28'd0, acks & acks_prev}, 32'd0);
      if (ack_exp.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ack: got acks %b, expected none", acks);
      end else begin
        ae = ack_exp.pop_front();
        chk("ack_client", {28'd0, acks}, {28'd0, 4'b0001 << ae.cl});
        if (ae.chk_rd) chk("ack_rdata", {24'd0, rdata}, {24'd0, ae.rd});
      end
    end
    acks_prev = acks;
    if (memreq && !memreq_prev) begin
      mem_total++;
      req_len = 0;
      if (mem_exp.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_memreq: got memaddr %0h, expected no transaction", memaddr);
      end else begin
        me = mem_exp.pop_front();
        chk("memaddr", {9'd0, memaddr}, {9'd0, me.addr});
        chk("memwr", {31'd0, memwr}, {31'd0, me.wr});
        if (me.wr) chk("memwdata", {24'd0, memwdata}, {24'd0, me.wd});
      end
    end
    if (memreq) req_len++;
    else if (memreq_prev) last_len = req_len;
    memreq_prev = memreq;
  end

  task automatic set_req(input logic [1:0] cl, input logic v);
    case (cl)
      CL_CROM:   cromreq = v;
      CL_CHRRAM: chrramreq = v;
      CL_PROM:   promreq = v;
      default:   prgramreq = v;
    endcase
  endtask

  function automatic logic ack_of(input logic [1:0] cl);
    logic [3:0] a;
    a = {prgramack, promack, chrramack, cromack};
    return a[cl];
  endfunction

  // Raise a request, hold it through the ack cycle, then drop it.
  task automatic txn(input logic [1:0] cl, input int bound, output int lat);
    int start;
    @(posedge clk);
    #1;
    start = cyc;
    lat = -1;
    set_req(cl, 1'b1);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (ack_of(cl)) begin
        lat = cyc - start;
        break;
      end
    end
    if (lat < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL ack_wait: no ack from client %0d within %0d cycles", cl, bound);
    end
    @(posedge clk);
    #1;
    set_req(cl, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base_ack;
    int base_mem;
    int seen;
    bit done_p;
    bit done_g;

    repeat (2) @(negedge clk);
    chk("rst_memreq", {31'd0, memreq}, 32'd0);
    chk("rst_memwr", {31'd0, memwr}, 32'd0);
    chk("rst_memaddr", {9'd0, memaddr}, 32'd0);
    chk("rst_memwdata", {24'd0, memwdata}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_acks", {28'd0, prgramack, promack, chrramack, cromack}, 32'd0);
    resetn = 1'b1;

    // All four held: rotation starts at client 0 after reset.
    mem_mode   = 1;
    mem_data   = 8'h77;
    cromaddr   = 21'h000020;
    chrramaddr = 13'h0040;
    promaddr   = 21'h000010;
    prgramaddr = 15'h0030;
    for (int r = 0; r < 2; r++) begin
      mem_exp.push_back('{23'h200020, 1'b0, 8'h00});
      ack_exp.push_back('{CL_CROM, 8'h77, 1'b1});
      mem_exp.push_back('{23'h408040, 1'b0, 8'h00});
      ack_exp.push_back('{CL_CHRRAM, 8'h77, 1'b1});
      mem_exp.push_back('{23'h000010, 1'b0, 8'h00});
      ack_exp.push_back('{CL_PROM, 8'h77, 1'b1});
      mem_exp.push_back('{23'h400030, 1'b0, 8'h00});
      ack_exp.push_back('{CL_PRGRAM, 8'h77, 1'b1});
    end
    @(posedge clk);
    #1;
    base_ack = ack_total;
    base_mem = mem_total;
    cromreq = 1'b1; chrramreq = 1'b1; promreq = 1'b1; prgramreq = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && seen < 2; i++) begin
      @(negedge clk);
      if (prgramack) seen++;
    end
    cromreq = 1'b0; chrramreq = 1'b0; promreq = 1'b0; prgramreq = 1'b0;
    chk("rr_two_rounds_seen", seen, 2);
    repeat (5) @(negedge clk);
    chk("rr_ack_count", ack_total - base_ack, 8);
    chk("rr_mem_count", mem_total - base_mem, 8);

    // Single PRG ROM read; req still high in the ack cycle must not reissue.
    promaddr = 21'h012345;
    mem_data = 8'hA5;
    mem_exp.push_back('{23'h012345, 1'b0, 8'h00});
    ack_exp.push_back('{CL_PROM, 8'hA5, 1'b1});
    base_mem = mem_total;
    txn(CL_PROM, 20, lat);
    chk("prom_latency", lat, 3);
    chk("prom_memreq_len", last_len, 1);
    repeat (4) @(negedge clk);
    chk("stale_no_reissue", mem_total - base_mem, 1);

    // CHR RAM write at the top of its window.
    chrramaddr  = 13'h1FFF;
    chrramwdata = 8'h3C;
    chrramwr    = 1'b1;
    mem_data    = 8'h11;
    mem_exp.push_back('{23'h409FFF, 1'b1, 8'h3C});
    ack_exp.push_back('{CL_CHRRAM, 8'h00, 1'b0});
    base_ack = ack_total;
    txn(CL_CHRRAM, 20, lat);
    chrramwr = 1'b0;
    chk("chrram_latency", lat, 3);
    repeat (4) @(negedge clk);
    chk("chrram_ack_once", ack_total - base_ack, 1);

    // Hung memory: abort after TIMEOUT cycles of memreq.
    mem_mode   = 0;
    prgramaddr = 15'h0123;
    mem_exp.push_back('{23'h400123, 1'b0, 8'h00});
    ack_exp.push_back('{CL_PRGRAM, 8'hFF, 1'b1});
    txn(CL_PRGRAM, 300, lat);
    chk("tmo_memreq_len", last_len, 255);
    chk("tmo_latency", lat, 257);
    chk("tmo_flag", {31'd0, timeout}, 32'd1);

    // Flag stays set across a later successful transaction.
    mem_mode = 1;
    mem_data = 8'h5A;
    cromaddr = 21'h1ABCDE;
    mem_exp.push_back('{23'h3ABCDE, 1'b0, 8'h00});
    ack_exp.push_back('{CL_CROM, 8'h5A, 1'b1});
    txn(CL_CROM, 20, lat);
    chk("crom_latency", lat, 3);
    chk("tmo_sticky", {31'd0, timeout}, 32'd1);

    // Reset while in ISSUE: memreq drops at once, no ack follows.
    mem_mode = 0;
    promaddr = 21'h000777;
    mem_exp.push_back('{23'h000777, 1'b0, 8'h00});
    @(posedge clk);
    #1;
    promreq = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clk);
      if (memreq) seen = 1;
    end
    chk("rstmid_reached_issue", seen, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rstmid_memreq_async", {31'd0, memreq}, 32'd0);
    chk("rstmid_timeout_clr", {31'd0, timeout}, 32'd0);
    promreq = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Pointer back at 0: PRG ROM (2) beats PRG RAM (3).
    mem_mode   = 1;
    mem_data   = 8'hC3;
    promaddr   = 21'h000100;
    prgramaddr = 15'h7FFF;
    mem_exp.push_back('{23'h000100, 1'b0, 8'h00});
    ack_exp.push_back('{CL_PROM, 8'hC3, 1'b1});
    mem_exp.push_back('{23'h407FFF, 1'b0, 8'h00});
    ack_exp.push_back('{CL_PRGRAM, 8'hC3, 1'b1});
    @(posedge clk);
    #1;
    base_ack = ack_total;
    promreq   = 1'b1;
    prgramreq = 1'b1;
    done_p = 1'b0;
    done_g = 1'b0;
    for (int i = 0; i < 30 && !(done_p && done_g); i++) begin
      @(negedge clk);
      if (promack) begin done_p = 1'b1; promreq = 1'b0; end
      if (prgramack) begin done_g = 1'b1; prgramreq = 1'b0; end
    end
    promreq   = 1'b0;
    prgramreq = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_ack_count", ack_total - base_ack, 2);
    chk("ack_queue_drained", ack_exp.size(), 0);
    chk("mem_queue_drained", mem_exp.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
